// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state type shared by alu_seq and its datapath
package alu_pkg;
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_logic.sv
// alu_seq_logic: single-cycle ops (ADD with overflow, OR, XOR, AND)
// ports: a_i/b_i post-inversion operands, cin_i, sign_i, op_i in; res_o, ofl_o out
module alu_seq_logic
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sign_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ofl_o
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  always_comb begin
    res_o = op_i == OP_ADD ? sum[WIDTH-1:0] : op_i == OP_OR ? a_i | b_i : op_i == OP_XOR ? a_i ^ b_i : a_i & b_i;
    ofl_o = op_i != OP_ADD ? 1'b0 : sign_i ? sum[WIDTH-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ sum[WIDTH] : sum[WIDTH];
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU, shifts/rotates one bit per clock
// ports: in_valid/in_ready request side (A, B, Cin, Op, invA, invB, sign); out_valid/out_ready result side (Out, Ofl, Z)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z
);
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d, a, b, res, step;
  logic ofl_q, ofl_d, z_q, z_d, ofl;
  assign a = invA ? ~A : A;
  assign b = invB ? ~B : B;
  alu_seq_logic #(.WIDTH(WIDTH)) u_logic (
    .a_i(a), .b_i(b), .cin_i(Cin), .sign_i(sign), .op_i(Op), .res_o(res), .ofl_o(ofl)
  );
  assign step = op_q == OP_ROL ? {out_q[WIDTH-2:0], out_q[WIDTH-1]} :
                op_q == OP_SLL ? {out_q[WIDTH-2:0], 1'b0} :
                op_q == OP_SRA ? {out_q[WIDTH-1], out_q[WIDTH-1:1]} : {1'b0, out_q[WIDTH-1:1]};
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign Out = out_q;
  assign Ofl = ofl_q;
  assign Z   = z_q;
  // Op[2] marks the single-cycle ops; shift ops preload the result register with a
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ofl_d   = ofl_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        op_d    = Op;
        cnt_d   = b[SHW-1:0];
        out_d   = Op[2] ? res : a;
        ofl_d   = Op[2] ? ofl : 1'b0;
        z_d     = ~|out_d;
        state_d = !Op[2] && |b[SHW-1:0] ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        out_d   = step;
        cnt_d   = cnt_q - SHW'(1);
        z_d     = ~|out_d;
        state_d = cnt_q == SHW'(1) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ROL;
      cnt_q   <= '0;
      out_q   <= '0;
      ofl_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ofl_q   <= ofl_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed and random requests
module tb_alu_seq;
  import alu_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, Cin = 0, invA = 0, invB = 0, sign = 0;
  logic out_valid, out_ready, Ofl, Z;
  logic [15:0] A = 0, B = 0, Out;
  logic [2:0] Op = 0;
  typedef struct {logic [15:0] out; logic ofl; logic z; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit rand_bp = 0, ready_force = 1, seen = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .Op(Op), .invA(invA), .invB(invB), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Ofl(Ofl), .Z(Z)
  );
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sg);
    exp_t e;
    int n;
    logic [16:0] s;
    n = int'(b[3:0]);
    e.ofl = 0;
    e.due = 1;
    case (op)
      OP_ROL: e.out = 16'((32'(a) << n) | (32'(a) >> (16 - n)));
      OP_SLL: e.out = 16'(32'(a) << n);
      OP_SRA: e.out = 16'($signed(a) >>> n);
      OP_SRL: e.out = a >> n;
      OP_ADD: begin
        s = 17'(a) + 17'(b) + 17'(cin);
        e.out = s[15:0];
        e.ofl = sg ? (a[15] == b[15] && s[15] != a[15]) : s[16];
      end
      OP_OR:  e.out = a | b;
      OP_XOR: e.out = a ^ b;
      default: e.out = a & b;
    endcase
    if (op < OP_ADD && n != 0) e.due = n + 1;
    e.z = e.out == 0;
    return e;
  endfunction
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end
  always @(negedge clk) if (!rst && out_valid) begin
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_valid: got Out=%0h with no pending request (cycle %0d)", Out, cyc);
    end else begin
      if (!seen) chk("latency", cyc, q[0].due);
      chk("Out", Out, q[0].out);
      chk("Ofl", Ofl, q[0].ofl);
      chk("Z", Z, q[0].z);
      seen = !out_ready;
      if (out_ready) void'(q.pop_front());
    end
  end
  task automatic issue(input logic [2:0] op, input logic [15:0] a_in, input logic [15:0] b_in,
                       input logic cin, input logic ia, input logic ib, input logic sg);
    exp_t e;
    int k = 0;
    e = model(op, ia ? ~a_in : a_in, ib ? ~b_in : b_in, cin, sg);
    @(posedge clk);
    #1;
    Op = op; A = a_in; B = b_in; Cin = cin; invA = ia; invB = ib; sign = sg; in_valid = 1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 500);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 500 cycles");
    end else begin
      e.due += cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain;
    int k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results required 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Out", Out, 0);
    chk("rst_Ofl", Ofl, 0);
    chk("rst_Z", Z, 0);
    @(posedge clk);
    #1 rst = 0;
    issue(OP_ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 0, 0, 0, 0);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 0, 0, 0, 1);
    drain();
    issue(OP_ROL, 16'h8001, 16'h0004, 0, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
    end
    issue(OP_SRA, 16'h7FF0, 16'h0003, 0, 1, 0, 0);
    issue(OP_SRL, 16'h1234, 16'h0010, 0, 0, 0, 0);
    drain();
    ready_force = 0;
    issue(OP_XOR, 16'hF0F0, 16'hFF00, 0, 0, 0, 0);
    Op = OP_OR; A = 16'h1111; B = 16'h2222; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_Out", Out, 16'h0FF0);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    ready_force = 1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    issue(OP_SLL, 16'h0001, 16'h000F, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_Out", Out, 0);
    repeat (20) @(negedge clk);
    issue(OP_AND, 16'hFF00, 16'h0FF0, 0, 0, 0, 0);
    drain();
    rand_bp = 1;
    repeat (40) issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_bp = 0;
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle, handshaked counterpart to the combinational alu_hier. It accepts one operation per request on a valid/ready interface and executes the same 8-op set. Shifts and rotates run iteratively, one bit position per clock; the other ops take a single cycle. The result is held on a valid/ready output port until it is consumed. It sits between the issue logic and writeback, where a registered, back-pressurable ALU result is needed.

Parameters:
WIDTH, 16, operand/result width; must be a power of two.
SHW, 4, shift-amount width, equal to log2(WIDTH); the shift amount is B[SHW-1:0].

Ports:
clk  in  1  single clock, rising-edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
A  in  WIDTH  operand A, before inversion.
B  in  WIDTH  operand B, before inversion.
Cin  in  1  carry-in, used by add only.
Op  in  3  opcode: 000 ROL, 001 SLL, 010 SRA, 011 SRL, 100 ADD, 101 OR, 110 XOR, 111 AND.
invA  in  1  invert A before the op.
invB  in  1  invert B before the op.
sign  in  1  selects signed overflow for ADD.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
Out  out  WIDTH  result.
Ofl  out  1  overflow; meaningful for ADD, 0 for all other ops.
Z  out  1  1 when Out == 0, for all ops.

Behaviour:
- Reset: rst is sampled at the rising edge of clk. Reset values:
  - state = IDLE, in_ready = 1
  - out_valid = 0, Out = 0, Ofl = 0, Z = 0
  - internal count = 0
- rst during SHIFT or DONE discards the operation in flight. No out_valid is produced for it.
- Request handshake: a request is accepted at the edge where in_valid && in_ready.
  - On acceptance, register a = invA ? ~A : A and b = invB ? ~B : B.
  - Also register Op, Cin, sign, and count = b[SHW-1:0].
- States:
  - IDLE: in_ready = 1.
    - Accepted shift/rotate op with count != 0 -> SHIFT.
    - Any other accepted op -> DONE, with the result computed combinationally and registered at that edge.
    - Shift op with count == 0 -> DONE with Out = a.
  - SHIFT: in_ready = 0. Each edge performs one 1-bit step on the result register and decrements count.
    - ROL: {r[W-2:0], r[W-1]}
    - SLL: {r[W-2:0], 0}
    - SRA: {r[W-1], r[W-1:1]}
    - SRL: {0, r[W-1:1]}
    - When count reaches 1 (the last step), go to DONE.
  - DONE: out_valid = 1 and in_ready = 0. Out, Ofl and Z stay stable while out_valid && !out_ready.
    - When out_ready = 1: next state IDLE, out_valid deasserts next cycle.
    - in_valid is ignored in DONE; there is no overlap of result and next request.
- Latency: out_valid is high 1 cycle after the handshake cycle for ADD, OR, XOR, AND, and for shifts with count 0. For shift/rotate with count = n, it is high n+1 cycles after the handshake cycle.
- ADD arithmetic: {c, s} = a + b + Cin, computed at WIDTH+1 bits; Out = s.
  - sign = 1: Ofl = s[W-1] ^ a[W-1] ^ b[W-1] ^ c.
  - sign = 0: Ofl = c.
- OR, XOR, AND: Ofl = 0.
- Z is registered together with Out. It is 1 exactly when the registered Out == 0.
- Only B[SHW-1:0] affects shifts; the upper bits of B are ignored. A count of WIDTH is not representable.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ROL, OP_SLL, OP_SRA, OP_SRL, OP_ADD, OP_OR, OP_XOR, OP_AND
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
- Sub-module alu_seq_logic (combinational) computes the one-cycle ops: ADD with Ofl, plus OR, XOR and AND.
- The shift datapath and FSM stay in alu_seq.

Test Plan:
1. ADD, A=7FFF, B=0001, Cin=0, sign=1 -> Out=8000, Ofl=1, Z=0; out_valid 1 cycle after the handshake.
2. ADD, A=FFFF, B=0001, Cin=0, sign=0 -> Out=0000, Ofl=1, Z=1. Same inputs with sign=1 -> Ofl=0.
3. ROL, A=8001, B=0004 -> Out=0018; out_valid 5 cycles after the handshake; in_ready=0 in every cycle between.
4. SRA, A=7FF0, invA=1 (a=800F), B=0003 -> Out=F001, latency 4. SRL, A=1234, B=0010 (count 0) -> Out=1234, latency 1.
5. Backpressure: XOR, A=F0F0, B=FF00 -> Out=0FF0.
   - Hold out_ready=0 for 3 cycles: Out and out_valid stay stable, in_ready=0, a concurrent in_valid is not accepted.
   - Raise out_ready: next cycle out_valid=0 and in_ready=1.
6. Reset mid-shift: SLL, A=0001, B=000F; assert rst 5 cycles after the handshake.
   - Next cycle: out_valid=0, in_ready=1, Out=0, and no stale result appears afterwards.
   - Then AND, A=FF00, B=0FF0 -> Out=0F00.
